bus_source_arbiter: RTL
=======================

// Module: bus_source_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 32-source datapath bus between requesting sources.
//   Source index i maps to bus select code i: 0-15 R0-R15, 16 HI, 17 LO, 18 Z_HI, 19 Z_LO,
//   20 PC, 21 MDR, 22 InPort, 23 C_sign_ext, 24-31 spare.
//   It drives the bus multiplexer select and returns a one-hot grant to the winning source.
//   It sits between the control unit (the requesters) and the bus mux select input.
// PARAMETERS
//   NUM_SRC   32  number of bus sources; must be a power of 2 and >= 2
//   SEL_W     5   select width; must equal $clog2(NUM_SRC)
//   MAX_HOLD  4   max consecutive owned cycles while another source is waiting; >= 1
// PORTS
//   clock          in   1        rising-edge clock
//   clear          in   1        asynchronous, active-high reset
//   req            in   NUM_SRC  per-source bus request; level-held while the source wants the bus
//   bus_sel        out  SEL_W    registered select code to the bus mux
//   grant          out  NUM_SRC  registered one-hot grant; all zero when idle
//   bus_valid      out  1        high when a source owns the bus (== |grant)
//   hold_cnt       out  3        cycles the current owner has held the bus, saturating at MAX_HOLD
// BEHAVIOUR
//   - Reset (async, clear=1): bus_sel=0, grant=0, bus_valid=0, hold_cnt=0,
//     last_owner=NUM_SRC-1, FSM=IDLE. Consequence: source 0 has top priority after reset.
//   - FSM IDLE: if req!=0, pick winner W by rotating priority starting at last_owner+1
//     (wraps NUM_SRC-1 -> 0). Next edge: grant=1<<W, bus_sel=W, hold_cnt=1, FSM=OWN.
//     Request-to-grant latency is 1 cycle.
//   - FSM OWN, owner O; others = req with bit O masked:
//     * req[O]=0, others!=0: rearbitrate from O+1. The new grant is driven the next
//       cycle (no dead cycle). last_owner=O.
//     * req[O]=0, others==0: grant=0, bus_valid=0, hold_cnt=0, FSM=IDLE. last_owner=O.
//       bus_sel keeps its last value.
//     * req[O]=1, others!=0, hold_cnt==MAX_HOLD: preempt. Winner is picked from O+1
//       (O is excluded this round). last_owner=O.
//     * req[O]=1, all other cases: keep the grant; hold_cnt saturates at MAX_HOLD.
//       When others==0, ownership continues indefinitely.
//   - hold_cnt reloads to 1 on every new grant.
//   - Simultaneous requests: only rotating priority decides. There is no fixed priority.
//   - Request bits for spare indices 24-31 arbitrate normally.
//   - grant is always one-hot or zero. bus_sel always equals the index of the set grant bit
//     while bus_valid=1.
//   - A clear asserted mid-ownership drops grant immediately (asynchronously) and
//     restarts priority at source 0.
//   - All outputs are registered. No combinational path from req to any output.
// CONFIGURATION
//   BUS_ARB_CONTENTION_CNT_EN defined:
//     - Adds output contention_cnt [15:0].
//     - It counts cycles in which popcount(req)>=2 and saturates at 16'hFFFF.
//     - It resets to 0 on clear.
//   BUS_ARB_CONTENTION_CNT_EN undefined: no port and no counter logic. Arbitration is
//     identical in both builds.
// STRUCTURE
//   - Package bus_arb_pkg holds:
//     * SRC_* index localparams (SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO,
//       SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN).
//     * FSM state encoding (ST_IDLE=1'b0, ST_OWN=1'b1).
//   - Sub-module rr_pick: purely combinational rotating priority encoder.
//     * Inputs: req vector and start index.
//     * Outputs: winner index and found flag.
//     * Implementation: a double-width vector, a find-first-set, then modulo NUM_SRC.
//   - Top level: FSM, owner/last_owner registers, hold counter, optional contention counter.
// TESTING
//   1. Reset, then req=bit20 (PC).
//      -> Next cycle: grant=1<<20, bus_sel=20, bus_valid=1, hold_cnt=1.
//   2. From reset, req=bits{3,21} held.
//      -> Grant sequence: 3 for 4 cycles, 21 for 4 cycles, 3 again.
//      -> hold_cnt runs 1,2,3,4 for each owner.
//   3. Owner 5 alone for 10 cycles.
//      -> Grant stays on 5; hold_cnt saturates at 4.
//      Then req[9] rises -> next cycle grant moves to 9.
//   4. Owner 31 drops req while req[0] is high.
//      -> Next cycle: grant=1<<0, bus_sel=0 (wrap-around, no idle cycle).
//   5. clear pulsed mid-cycle while owner 12 holds.
//      -> grant=0, bus_sel=0 immediately.
//      Then req={12,0} -> grant 0 first.
//   6. With BUS_ARB_CONTENTION_CNT_EN: req={1,2} held for 7 cycles.
//      -> contention_cnt=7.
//      Without the macro, the bench compiles with no contention_cnt port.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus source arbiter: source index map and FSM encoding.
package bus_arb_pkg;

   // Bus source indices; each index is also the bus mux select code.
   localparam int SRC_R0     = 0;
   localparam int SRC_R1     = 1;
   localparam int SRC_R2     = 2;
   localparam int SRC_R3     = 3;
   localparam int SRC_R4     = 4;
   localparam int SRC_R5     = 5;
   localparam int SRC_R6     = 6;
   localparam int SRC_R7     = 7;
   localparam int SRC_R8     = 8;
   localparam int SRC_R9     = 9;
   localparam int SRC_R10    = 10;
   localparam int SRC_R11    = 11;
   localparam int SRC_R12    = 12;
   localparam int SRC_R13    = 13;
   localparam int SRC_R14    = 14;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_CSIGN  = 23;

   // Arbiter FSM: either nobody owns the bus or exactly one source does.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: returns the first set request at or
// after 'start', wrapping past NUM_SRC-1 back to 0.
module rr_pick #(
   parameter int NUM_SRC = 32,
   parameter int SEL_W   = 5
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   start,
   output logic [SEL_W-1:0]   winner,
   output logic               found
);

   logic [2*NUM_SRC-1:0] dbl;

   // Scan the doubled request vector downward so the lowest index >= start wins;
   // the upper copy supplies the wrapped-around candidates.
   always_comb begin
      dbl    = {req, req};
      winner = {SEL_W{1'b0}};
      found  = 1'b0;
      for (int j = 2*NUM_SRC-1; j >= 0; j--) begin
         winner = ((j >= int'(start)) && dbl[j]) ? SEL_W'(j % NUM_SRC) : winner;
         found  = ((j >= int'(start)) && dbl[j]) ? 1'b1 : found;
      end
   end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for the shared datapath bus. Drives the registered mux
// select and a one-hot grant. Optional macro BUS_ARB_CONTENTION_CNT_EN adds a
// saturating count of cycles with two or more simultaneous requesters.
module bus_source_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_SRC  = 32,
   parameter int SEL_W    = 5,
   parameter int MAX_HOLD = 4
) (
   input  logic               clock,
   input  logic               clear,
   input  logic [NUM_SRC-1:0] req,
   output logic [SEL_W-1:0]   bus_sel,
   output logic [NUM_SRC-1:0] grant,
   output logic               bus_valid,
   output logic [2:0]         hold_cnt
`ifdef BUS_ARB_CONTENTION_CNT_EN
   ,
   output logic [15:0]        contention_cnt
`endif
);

   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
   localparam logic [2:0]       HOLD_MAX = 3'(MAX_HOLD);

   state_t               state, state_nxt;
   logic [SEL_W-1:0]     last_owner, last_owner_nxt;
   logic [SEL_W-1:0]     bus_sel_nxt;
   logic [NUM_SRC-1:0]   grant_nxt;
   logic [2:0]           hold_nxt;
   logic [NUM_SRC-1:0]   others;
   logic                 own_req;
   logic [SEL_W-1:0]     pick_start;
   logic [SEL_W-1:0]     pick_winner;
   logic                 pick_found;
   logic                 take_new;

   // Candidates exclude the current owner; rotation starts just past the
   // current owner while owning, or past the last owner while idle.
   always_comb begin
      others     = req & ~grant;
      own_req    = |(req & grant);
      pick_start = (state == ST_OWN) ? (bus_sel + SEL_ONE) : (last_owner + SEL_ONE);
   end

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_rr_pick (
      .req    (others),
      .start  (pick_start),
      .winner (pick_winner),
      .found  (pick_found)
   );

   // Next-state decode: grant, handoff, preemption, release and hold counting.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      bus_sel_nxt    = bus_sel;
      grant_nxt      = grant;
      hold_nxt       = hold_cnt;
      take_new       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               take_new = 1'b1;
            end else begin
               hold_nxt = 3'd0;
            end
         end
         ST_OWN: begin
            if (!own_req) begin
               last_owner_nxt = bus_sel;
               if (pick_found) begin
                  take_new = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
                  grant_nxt = {NUM_SRC{1'b0}};
                  hold_nxt  = 3'd0;
               end
            end else if (pick_found && (hold_cnt == HOLD_MAX)) begin
               last_owner_nxt = bus_sel;
               take_new       = 1'b1;
            end else begin
               hold_nxt = (hold_cnt < HOLD_MAX) ? (hold_cnt + 3'd1) : hold_cnt;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = {NUM_SRC{1'b0}};
            hold_nxt  = 3'd0;
         end
      endcase
      if (take_new) begin
         state_nxt              = ST_OWN;
         bus_sel_nxt            = pick_winner;
         grant_nxt              = {NUM_SRC{1'b0}};
         grant_nxt[pick_winner] = 1'b1;
         hold_nxt               = 3'd1;
      end else begin
         bus_sel_nxt = bus_sel_nxt;
      end
   end

   // Arbiter state and registered outputs; clear restarts priority at source 0.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state      <= ST_IDLE;
         last_owner <= SEL_W'(NUM_SRC - 1);
         bus_sel    <= {SEL_W{1'b0}};
         grant      <= {NUM_SRC{1'b0}};
         bus_valid  <= 1'b0;
         hold_cnt   <= 3'd0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         bus_sel    <= bus_sel_nxt;
         grant      <= grant_nxt;
         bus_valid  <= |grant_nxt;
         hold_cnt   <= hold_nxt;
      end
   end

`ifdef BUS_ARB_CONTENTION_CNT_EN
   logic multi_req;

   // Two or more requesters: clearing the lowest set bit still leaves a bit set.
   always_comb begin
      multi_req = |(req & (req - {{(NUM_SRC-1){1'b0}}, 1'b1}));
   end

   // Saturating count of contended cycles.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         contention_cnt <= 16'h0000;
      end else if (multi_req && (contention_cnt != 16'hFFFF)) begin
         contention_cnt <= contention_cnt + 16'h0001;
      end else begin
         contention_cnt <= contention_cnt;
      end
   end
`endif

endmodule
